// File: rtl/lif_pkg.sv
// Shared constants and helpers for the LIF neuron array.
package lif_pkg;

  localparam int LIF_RST_ZERO = 0;
  localparam int LIF_RST_SUB  = 1;

  // Bits needed to hold a refractory count of 0..refrac, never less than one.
  function automatic int refrac_w(input int refrac);
    int w;
    w = $clog2(refrac + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire channel: leak, integrate, saturate, fire, refractory hold.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = LIF_RST_ZERO
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         upd,
  input  logic         clr,
  input  logic [W-1:0] thresh,
  input  logic [W-1:0] current,
  output logic [W-1:0] v,
  output logic         spike,
  output logic         sat
);

  localparam int RW = refrac_w(REFRAC);

  logic [RW-1:0] ref_q;
  logic [W:0]    sum_raw;
  logic [W-1:0]  sum_c;
  logic          ovf;
  logic          fire;

  // Leak never exceeds V, so the subtraction cannot underflow.
  always_comb begin
    sum_raw = {1'b0, v - (v >> LEAK_SHIFT)} + {1'b0, current};
    ovf     = sum_raw[W];
    sum_c   = ovf ? {W{1'b1}} : sum_raw[W-1:0];
    fire    = (thresh != '0) && (sum_c >= thresh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      ref_q <= '0;
      spike <= 1'b0;
      sat   <= 1'b0;
    end else if (clr) begin
      v     <= '0;
      ref_q <= '0;
      spike <= 1'b0;
      sat   <= 1'b0;
    end else if (upd) begin
      if (ref_q != '0) begin
        ref_q <= ref_q - 1'b1;
        spike <= 1'b0;
        sat   <= 1'b0;
      end else begin
        sat   <= ovf;
        spike <= fire;
        if (fire) begin
          ref_q <= RW'(REFRAC);
          v     <= (RESET_MODE == LIF_RST_SUB) ? sum_c - thresh : '0;
        end else begin
          v <= sum_c;
        end
      end
    end else begin
      spike <= 1'b0;
      sat   <= 1'b0;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Array of N_CH LIF neurons updated together on a qualified tick strobe.
module lif_array
  import lif_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int RESET_MODE = LIF_RST_ZERO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              tick,
  input  logic              clr,
  input  logic [W-1:0]      thresh,
  input  logic [N_CH*W-1:0] current,
  output logic [N_CH-1:0]   spike,
  output logic              spike_any,
  output logic [N_CH*W-1:0] state,
  output logic [N_CH-1:0]   sat
);

  logic upd;

  // clr has priority inside each neuron, so upd need not exclude it.
  assign upd = ena & tick;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lif_neuron #(
      .W          (W),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC),
      .RESET_MODE (RESET_MODE)
    ) u_neuron (
      .clk     (clk),
      .rst     (rst),
      .upd     (upd),
      .clr     (clr),
      .thresh  (thresh),
      .current (current[i*W +: W]),
      .v       (state[i*W +: W]),
      .spike   (spike[i]),
      .sat     (sat[i])
    );
  end

  assign spike_any = |spike;

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array: vector table plus hand sequences for reset, saturation and subtractive reset.
module tb_lif_array;
  import lif_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        tick = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  thresh = 8'd100;
  logic [31:0] current = '0;

  logic [3:0]  spike_a, sat_a, spike_b, sat_b;
  logic        any_a, any_b;
  logic [31:0] state_a, state_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lif_array #(.N_CH(4), .W(8), .LEAK_SHIFT(1), .REFRAC(2), .RESET_MODE(LIF_RST_ZERO)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .tick(tick), .clr(clr), .thresh(thresh),
    .current(current), .spike(spike_a), .spike_any(any_a), .state(state_a), .sat(sat_a)
  );

  lif_array #(.N_CH(4), .W(8), .LEAK_SHIFT(1), .REFRAC(0), .RESET_MODE(LIF_RST_SUB)) u_sub (
    .clk(clk), .rst(rst), .ena(ena), .tick(tick), .clr(clr), .thresh(thresh),
    .current(current), .spike(spike_b), .spike_any(any_b), .state(state_b), .sat(sat_b)
  );

  typedef struct {
    logic        ena, tick, clr;
    logic [7:0]  thresh;
    logic [31:0] current;
    logic [31:0] exp_state;
    logic [3:0]  exp_spike;
    logic [3:0]  exp_sat;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic add(input logic e, input logic t, input logic c, input int th,
                     input logic [31:0] cur, input logic [31:0] st, input logic [3:0] sp,
                     input logic [3:0] sa);
    vec_t r;
    r.ena = e; r.tick = t; r.clr = c; r.thresh = 8'(th); r.current = cur;
    r.exp_state = st; r.exp_spike = sp; r.exp_sat = sa;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp2[8] = '{40, 60, 70, 75, 78, 79, 80, 80};
  int exp4[3] = '{20, 30, 35};

  initial begin
    // Reset state
    cyc(); cyc();
    check("reset_state", state_a, 32'd0);
    check("reset_spike", {28'd0, spike_a}, 32'd0);
    check("reset_sat", {28'd0, sat_a}, 32'd0);
    check("reset_any", {31'd0, any_a}, 32'd0);
    rst = 1'b0;
    ena = 1'b1;

    // Integration with leak on ch0, converging to 80 without a spike
    add(1, 0, 1, 100, pk(0, 0, 0, 0), pk(0, 0, 0, 0), 4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++)
      add(1, 1, 0, 100, pk(40, 0, 0, 0), pk(exp2[i], 0, 0, 0), 4'b0000, 4'b0000);
    add(1, 0, 0, 100, pk(40, 0, 0, 0), pk(80, 0, 0, 0), 4'b0000, 4'b0000);
    add(0, 1, 0, 100, pk(40, 0, 0, 0), pk(80, 0, 0, 0), 4'b0000, 4'b0000);
    add(1, 1, 1, 100, pk(40, 0, 0, 0), pk(0, 0, 0, 0), 4'b0000, 4'b0000);
    // ch1 fires every third tick with refractory hold
    for (int i = 0; i < 8; i++)
      add(1, 1, 0, 100, pk(0, 120, 0, 0), pk(0, 0, 0, 0),
          (i % 3 == 0) ? 4'b0010 : 4'b0000, 4'b0000);
    // clr mid-refractory clears the count, so the next tick fires at once
    add(1, 1, 1, 100, pk(0, 120, 0, 0), pk(0, 0, 0, 0), 4'b0000, 4'b0000);
    add(1, 1, 0, 100, pk(0, 120, 0, 0), pk(0, 0, 0, 0), 4'b0010, 4'b0000);
    add(1, 0, 0, 100, pk(0, 120, 0, 0), pk(0, 0, 0, 0), 4'b0000, 4'b0000);

    foreach (vecs[k]) begin
      ena = vecs[k].ena; tick = vecs[k].tick; clr = vecs[k].clr;
      thresh = vecs[k].thresh; current = vecs[k].current;
      cyc();
      check($sformatf("vec%0d_state", k), state_a, vecs[k].exp_state);
      check($sformatf("vec%0d_spike", k), {28'd0, spike_a}, {28'd0, vecs[k].exp_spike});
      check($sformatf("vec%0d_sat", k), {28'd0, sat_a}, {28'd0, vecs[k].exp_sat});
      check($sformatf("vec%0d_any", k), {31'd0, any_a}, {31'd0, |vecs[k].exp_spike});
    end

    // Subtractive reset, no refractory period
    ena = 1'b1; tick = 1'b0; clr = 1'b1; thresh = 8'd100; current = pk(120, 0, 0, 0);
    cyc();
    clr = 1'b0; tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("sub_state%0d", i), {24'd0, state_b[7:0]}, 32'(exp4[i]));
      check($sformatf("sub_spike%0d", i), {28'd0, spike_b}, 32'd1);
    end
    tick = 1'b0;

    // Saturation with firing disabled
    clr = 1'b1; cyc();
    clr = 1'b0; thresh = 8'd0; current = pk(0, 0, 255, 0); tick = 1'b1;
    cyc();
    check("sat_t1_state", state_a, pk(0, 0, 255, 0));
    check("sat_t1_sat", {28'd0, sat_a}, 32'd0);
    cyc();
    check("sat_t2_state", state_a, pk(0, 0, 255, 0));
    check("sat_t2_sat", {28'd0, sat_a}, 32'b0100);
    check("sat_t2_spike", {28'd0, spike_a}, 32'd0);
    tick = 1'b0;

    // Asynchronous reset while the sat pulse and V are non-zero
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_state", state_a, 32'd0);
    check("arst_sat", {28'd0, sat_a}, 32'd0);
    check("arst_spike", {28'd0, spike_a}, 32'd0);
    rst = 1'b0;
    cyc(); cyc(); cyc();
    check("post_rst_hold", state_a, 32'd0);
    tick = 1'b1;
    cyc();
    check("post_rst_tick", state_a, pk(0, 0, 255, 0));
    check("post_rst_sat", {28'd0, sat_a}, 32'd0);
    tick = 1'b0;
    cyc();
    check("idle_hold", state_a, pk(0, 0, 255, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
